sram_nr1w: RTL and testbench
============================

# sram_nr1w

Parametrised register-file SRAM with one write port and NUM_RD independent read ports, replacing the fixed 2-read, 128-bit, 64K-word array. It adds registered reads with valid flags, byte-enable writes, a hardware clear sequencer after reset, and optional write-to-read forwarding. It sits beside the datapath as the main operand store, with one read port per consumer.

## Interface
Parameters:
- DATA_W, 128, word width in bits; must be a multiple of 8.
- ADDR_W, 16, address width.
- DEPTH, 1<<ADDR_W, number of words; must be ≤ 2^ADDR_W.
- NUM_RD, 2, number of read ports; must be ≥ 1.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- we  in  1  write request.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- wbe  in  DATA_W/8  byte enables; bit k covers wdata[8k+7:8k].
- re  in  NUM_RD  per-port read request.
- raddr  in  NUM_RD*ADDR_W  read addresses; port p uses bits [p*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  read data, packed the same way as raddr.
- rvalid  out  NUM_RD  per-port, one-cycle pulse marking rdata valid.
- busy  out  1  high while the clear sequence runs.

## Operation
- Two-state FSM, CLEAR and READY.
  - Reset enters CLEAR with clear counter = 0.
  - In CLEAR, each cycle writes all-zero to word[counter], then increments the counter.
  - When counter = DEPTH-1 is written, the next state is READY.
- While busy = 1:
  - we and re are ignored; no array update from the host port.
  - rvalid stays 0.
- Write in READY:
  - If we = 1 and waddr < DEPTH, bytes with wbe = 1 take wdata; all other bytes keep their value.
  - If wbe = 0, the write is a no-op.
  - If waddr ≥ DEPTH, the write is dropped silently.
- Read in READY, port p with re[p] = 1:
  - The addressed word is captured into the port's output register.
  - rvalid[p] = 1 in the following cycle.
  - If raddr ≥ DEPTH, rdata = 0 and rvalid still pulses.
- Read with re[p] = 0: rdata[p] holds its last value and rvalid[p] = 0.
- Read ports are fully independent. Any number of ports may read the same address in the same cycle.

## Timing
- Reset values:
  - busy = 1, rvalid = 0, all rdata = 0, state = CLEAR.
  - Array contents are undefined until the clear completes.
- Clear duration: busy falls exactly DEPTH cycles after the first clock edge with reset_n high.
- A reset asserted mid-clear restarts the sweep at word 0.
- A reset asserted in READY re-runs the full clear.
- Read latency is 1 cycle: address and re sampled at edge N; rdata and rvalid valid after edge N, through edge N+1.
- Write takes effect at the edge; a read of that address issued in the next cycle returns the new data.
- Same-cycle read and write to the same address: result depends on SRAM_BYPASS_EN (see Configuration).
- No combinational path from any input to any output.

## Configuration
- Macro SRAM_BYPASS_EN.
- Defined: a same-cycle read/write hit returns merged data. Bytes with wbe = 1 come from wdata; the rest come from the old array value.
- Undefined: read-before-write; rdata returns the old contents for all bytes.
- The macro has no effect on any other behaviour.

## Structure
- Package sram_pkg holds:
  - the state enum sram_state_e (CLEAR, READY);
  - default parameter constants SRAM_DATA_W, SRAM_ADDR_W, SRAM_NUM_RD;
  - a byte-merge function used by both the write path and the bypass path.
- Sub-module sram_read_port:
  - holds one port's output register, out-of-range zeroing, rvalid generation and the optional bypass merge;
  - instantiated NUM_RD times in a generate loop.
- Top level keeps the array, the write logic and the clear FSM.

## Test plan
Bench parameters: DATA_W = 32, ADDR_W = 4, DEPTH = 12, NUM_RD = 3.
- Release reset → busy = 1 for exactly 12 cycles, then 0. Reading addresses 0, 5 and 11 on ports 0, 1 and 2 returns 0x0 with rvalid = 3'b111 one cycle later.
- After clear, write 0xDEADBEEF to address 3 with wbe = 4'hF, then write 0x11223344 to address 3 with wbe = 4'b0101 → a subsequent read of address 3 returns 0xDE22BE44.
- Same cycle: write 0xAAAAAAAA to address 7 (wbe = 4'hF, old value 0x0) and read address 7 on port 1 → rdata = 0xAAAAAAAA with SRAM_BYPASS_EN defined, 0x00000000 without. The next-cycle read returns 0xAAAAAAAA in both builds.
- Write to address 13 (≥ DEPTH) → array unchanged. A read of address 13 returns 0x0 with rvalid = 1.
- Assert reset_n = 0 for 1 cycle while busy, at counter = 6 → busy stays high for a full 12 cycles after release. we and re issued during busy produce no rvalid and no array change.
- All three ports read address 3 while re toggles 1, 0, 1 → rvalid follows with 1-cycle lag, and rdata holds its value during the re = 0 cycle.

Source files
------------

// File: rtl/sram_pkg.sv
// ----------------------------------------------------------------------------
// sram_pkg
//
// Shared definitions for the sram_nr1w register-file SRAM:
//   - sram_state_e : clear-sequencer states (CLEAR, READY)
//   - SRAM_DATA_W / SRAM_ADDR_W / SRAM_NUM_RD : default geometry
//   - byte_merge() : one-byte select used by both the array write path and
//                    the read-port bypass path, so both merge identically.
// ----------------------------------------------------------------------------
package sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } sram_state_e;

    localparam int SRAM_DATA_W = 128;
    localparam int SRAM_ADDR_W = 16;
    localparam int SRAM_NUM_RD = 2;

    // Returns new_byte when its enable is set, otherwise keeps old_byte.
    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       en
    );
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/sram_read_port.sv
// ----------------------------------------------------------------------------
// sram_read_port
//
// One registered read port of sram_nr1w.
//   clock, reset_n : clock and asynchronous active-low reset
//   rd_en          : read request already qualified with "not busy"
//   addr           : read address
//   mem_word       : array word at addr (combinational read from the top)
//   wr_*           : host write of this cycle (only with SRAM_BYPASS_EN)
//   rdata          : registered read data, holds when rd_en = 0
//   rvalid         : one-cycle pulse, the cycle after a read request
//
// Optional feature macro SRAM_BYPASS_EN: a read that hits the address being
// written in the same cycle returns the byte-merged write data. Without it
// the port returns the pre-write array contents.
// ----------------------------------------------------------------------------
module sram_read_port
    import sram_pkg::*;
#(
    parameter int          DATA_W = 32,
    parameter int          ADDR_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   mem_word,
`ifdef SRAM_BYPASS_EN
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
`endif
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid
);

    logic [DATA_W-1:0] rdata_reg;
    logic              rvalid_reg;
    logic [DATA_W-1:0] word_sel;
    logic              in_range;

    // Addresses past the end of the array read back as zero.
    assign in_range = (32'(addr) < DEPTH);

`ifdef SRAM_BYPASS_EN
    logic hit;
    // wr_en is already range-checked, so a hit implies a real array write.
    assign hit = wr_en && (wr_addr == addr);

    for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_byp
        assign word_sel[gi*8 +: 8] = byte_merge(mem_word[gi*8 +: 8],
                                                wr_data[gi*8 +: 8],
                                                hit & wr_be[gi]);
    end
`else
    assign word_sel = mem_word;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            rvalid_reg <= rd_en;
            if (rd_en) begin
                rdata_reg <= in_range ? word_sel : '0;
            end
        end
    end

    assign rdata  = rdata_reg;
    assign rvalid = rvalid_reg;

endmodule

// File: rtl/sram_nr1w.sv
// ----------------------------------------------------------------------------
// sram_nr1w
//
// Register-file SRAM with one byte-enabled write port and NUM_RD independent
// registered read ports. After every reset a sequencer sweeps the array to
// zero (busy = 1) before host accesses are accepted.
//
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   we, waddr, wdata, wbe : write request, address, data, byte enables
//   re     [NUM_RD]        : per-port read request
//   raddr  [NUM_RD*ADDR_W] : read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rdata  [NUM_RD*DATA_W] : read data, port p at [p*DATA_W +: DATA_W]
//   rvalid [NUM_RD]        : per-port read-valid pulse
//   busy                   : high while the clear sweep runs
//
// Optional feature macro SRAM_BYPASS_EN: same-cycle write-to-read forwarding
// (implemented in sram_read_port).
// ----------------------------------------------------------------------------
module sram_nr1w
    import sram_pkg::*;
#(
    parameter int          DATA_W = SRAM_DATA_W,
    parameter int          ADDR_W = SRAM_ADDR_W,
    parameter int unsigned DEPTH  = 1 << ADDR_W,
    parameter int          NUM_RD = SRAM_NUM_RD
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      wbe,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rvalid,
    output logic                     busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    sram_state_e       state_reg;
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic              busy_reg;

    logic              wr_in_range;
    logic              wr_en;
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_merged;

    // ------------------------------------------------------------------
    // Clear sequencer: one word per cycle, busy drops on the edge that
    // writes the last word.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
            busy_reg    <= 1'b1;
        end else begin
            case (state_reg)
                CLEAR: begin
                    if (clr_cnt_reg == LAST_ADDR) begin
                        state_reg <= READY;
                        busy_reg  <= 1'b0;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    end
                end
                READY: begin
                    state_reg <= READY;
                end
                default: begin
                    state_reg <= CLEAR;
                    busy_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign busy = busy_reg;

    // ------------------------------------------------------------------
    // Write path: read-modify-write so unselected bytes keep their value.
    // ------------------------------------------------------------------
    assign wr_in_range = (32'(waddr) < DEPTH);
    assign wr_en       = we && !busy_reg && wr_in_range;
    assign wr_old      = mem[waddr];

    for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_wr_byte
        assign wr_merged[gi*8 +: 8] = byte_merge(wr_old[gi*8 +: 8],
                                                 wdata[gi*8 +: 8],
                                                 wbe[gi]);
    end

    // The array has no reset; its contents are defined by the clear sweep.
    always_ff @(posedge clock) begin
        if (busy_reg) begin
            mem[clr_cnt_reg] <= '0;
        end else if (wr_en) begin
            mem[waddr] <= wr_merged;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] port_addr;
        logic [DATA_W-1:0] port_word;

        assign port_addr = raddr[gi*ADDR_W +: ADDR_W];
        assign port_word = mem[port_addr];

        sram_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_port (
            .clock    (clock),
            .reset_n  (reset_n),
            .rd_en    (re[gi] && !busy_reg),
            .addr     (port_addr),
            .mem_word (port_word),
`ifdef SRAM_BYPASS_EN
            .wr_en    (wr_en),
            .wr_addr  (waddr),
            .wr_data  (wdata),
            .wr_be    (wbe),
`endif
            .rdata    (rdata[gi*DATA_W +: DATA_W]),
            .rvalid   (rvalid[gi])
        );
    end

endmodule

// File: tb/tb_sram_nr1w.sv
// ----------------------------------------------------------------------------
// tb_sram_nr1w
//
// Directed bench for sram_nr1w with DATA_W=32, ADDR_W=4, DEPTH=12, NUM_RD=3.
// Works for both builds; the same-cycle read/write expectation follows
// SRAM_BYPASS_EN.
// ----------------------------------------------------------------------------
module tb_sram_nr1w;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DP = 12;
    localparam int NR = 3;

`ifdef SRAM_BYPASS_EN
    localparam logic [31:0] BYP_EXP = 32'hAAAA_AAAA;
`else
    localparam logic [31:0] BYP_EXP = 32'h0000_0000;
`endif

    logic             clock = 1'b0;
    logic             reset_n;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    logic [DW/8-1:0]  wbe;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rvalid;
    logic             busy;

    int tests = 0;
    int fails = 0;
    int cyc;
    int rv_seen;

    sram_nr1w #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DP),
        .NUM_RD (NR)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .wbe     (wbe),
        .re      (re),
        .raddr   (raddr),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(input int p);
        return rdata[p*DW +: DW];
    endfunction

    task automatic set_rd(input logic [2:0] r, input logic [3:0] a0,
                          input logic [3:0] a1, input logic [3:0] a2);
        re    = r;
        raddr = {a2, a1, a0};
    endtask

    task automatic set_wr(input logic w, input logic [3:0] a,
                          input logic [31:0] d, input logic [3:0] be);
        we    = w;
        waddr = a;
        wdata = d;
        wbe   = be;
    endtask

    // Counts edges until busy drops (bounded), and how many of those cycles
    // showed any rvalid.
    task automatic wait_ready(output int cycles, output int rv_cnt);
        cycles = 0;
        rv_cnt = 0;
        while (busy === 1'b1 && cycles < 40) begin
            tick();
            cycles++;
            if (rvalid !== 3'b000) rv_cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        set_wr(1'b0, 4'd0, 32'h0, 4'h0);
        set_rd(3'b000, 4'd0, 4'd0, 4'd0);
        repeat (3) tick();

        // Reset state
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_rvalid", {29'b0, rvalid}, 32'd0);
        for (int p = 0; p < NR; p++) check($sformatf("rst_rdata%0d", p), rd(p), 32'h0);
        $display("[TB] reset: busy=%0b rvalid=%b", busy, rvalid);

        // Clear sweep length
        reset_n = 1'b1;
        wait_ready(cyc, rv_seen);
        check("clear_cycles", cyc, 32'd12);
        $display("[TB] clear done after %0d cycles", cyc);

        // Cleared contents on all ports
        set_rd(3'b111, 4'd0, 4'd5, 4'd11);
        tick();
        set_rd(3'b000, 4'd0, 4'd5, 4'd11);
        check("clr_rvalid", {29'b0, rvalid}, 32'd7);
        for (int p = 0; p < NR; p++) check($sformatf("clr_rdata%0d", p), rd(p), 32'h0);
        tick();
        check("clr_rvalid_drop", {29'b0, rvalid}, 32'd0);
        $display("[TB] read 0/5/11 after clear: %h %h %h", rd(0), rd(1), rd(2));

        // Byte-enable write
        set_wr(1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF);
        tick();
        set_wr(1'b1, 4'd3, 32'h1122_3344, 4'b0101);
        tick();
        set_wr(1'b0, 4'd0, 32'h0, 4'h0);
        set_rd(3'b001, 4'd3, 4'd0, 4'd0);
        tick();
        set_rd(3'b000, 4'd3, 4'd0, 4'd0);
        check("wbe_merge", rd(0), 32'hDE22_BE44);
        $display("[TB] byte-enable write addr3: %h", rd(0));

        // Same-cycle write and read
        set_wr(1'b1, 4'd7, 32'hAAAA_AAAA, 4'hF);
        set_rd(3'b010, 4'd0, 4'd7, 4'd0);
        tick();
        set_wr(1'b0, 4'd0, 32'h0, 4'h0);
        check("byp_rvalid", {29'b0, rvalid}, 32'd2);
        check("byp_rdata", rd(1), BYP_EXP);
        tick();
        set_rd(3'b000, 4'd0, 4'd7, 4'd0);
        check("byp_next_rdata", rd(1), 32'hAAAA_AAAA);
        $display("[TB] same-cycle rw addr7: next-cycle %h", rd(1));

        // Out-of-range write dropped, out-of-range read returns zero
        set_wr(1'b1, 4'd13, 32'h5555_5555, 4'hF);
        tick();
        set_wr(1'b0, 4'd0, 32'h0, 4'h0);
        set_rd(3'b111, 4'd13, 4'd3, 4'd7);
        tick();
        set_rd(3'b000, 4'd13, 4'd3, 4'd7);
        check("oor_rvalid", {29'b0, rvalid}, 32'd7);
        check("oor_rdata", rd(0), 32'h0);
        check("oor_addr3_kept", rd(1), 32'hDE22_BE44);
        check("oor_addr7_kept", rd(2), 32'hAAAA_AAAA);
        $display("[TB] out-of-range: rd13=%h rd3=%h rd7=%h", rd(0), rd(1), rd(2));

        // Reset from READY: asynchronous clear of output registers
        reset_n = 1'b0;
        #1;
        check("rst2_busy", {31'b0, busy}, 32'd1);
        check("rst2_rdata1", rd(1), 32'h0);
        tick();
        reset_n = 1'b1;
        // Host traffic during busy must be ignored
        set_wr(1'b1, 4'd2, 32'h1234_5678, 4'hF);
        set_rd(3'b111, 4'd2, 4'd2, 4'd2);
        repeat (6) tick();
        check("midclear_busy", {31'b0, busy}, 32'd1);
        check("midclear_rvalid", {29'b0, rvalid}, 32'd0);
        // Reset again at counter = 6
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        wait_ready(cyc, rv_seen);
        set_wr(1'b0, 4'd0, 32'h0, 4'h0);
        set_rd(3'b000, 4'd0, 4'd0, 4'd0);
        check("restart_cycles", cyc, 32'd12);
        check("busy_rvalid_cnt", rv_seen, 32'd0);
        $display("[TB] restarted clear took %0d cycles, rvalid seen %0d", cyc, rv_seen);

        set_rd(3'b111, 4'd2, 4'd3, 4'd7);
        tick();
        set_rd(3'b000, 4'd2, 4'd3, 4'd7);
        check("post_rvalid", {29'b0, rvalid}, 32'd7);
        check("busy_write_ignored", rd(0), 32'h0);
        check("reclear_addr3", rd(1), 32'h0);
        check("reclear_addr7", rd(2), 32'h0);
        $display("[TB] after re-clear: rd2=%h rd3=%h rd7=%h", rd(0), rd(1), rd(2));

        // re toggling 1,0,1 on all ports at address 3
        set_wr(1'b1, 4'd3, 32'hCAFE_F00D, 4'hF);
        tick();
        set_wr(1'b0, 4'd0, 32'h0, 4'h0);
        set_rd(3'b111, 4'd3, 4'd3, 4'd3);
        tick();
        check("tog1_rvalid", {29'b0, rvalid}, 32'd7);
        for (int p = 0; p < NR; p++) check($sformatf("tog1_rdata%0d", p), rd(p), 32'hCAFE_F00D);
        set_rd(3'b000, 4'd3, 4'd3, 4'd3);
        set_wr(1'b1, 4'd3, 32'h0102_0304, 4'hF);
        tick();
        set_wr(1'b0, 4'd0, 32'h0, 4'h0);
        check("tog0_rvalid", {29'b0, rvalid}, 32'd0);
        for (int p = 0; p < NR; p++) check($sformatf("tog0_hold%0d", p), rd(p), 32'hCAFE_F00D);
        set_rd(3'b111, 4'd3, 4'd3, 4'd3);
        tick();
        set_rd(3'b000, 4'd3, 4'd3, 4'd3);
        check("tog2_rvalid", {29'b0, rvalid}, 32'd7);
        for (int p = 0; p < NR; p++) check($sformatf("tog2_rdata%0d", p), rd(p), 32'h0102_0304);
        tick();
        check("tog3_rvalid", {29'b0, rvalid}, 32'd0);
        $display("[TB] re toggle on addr3: final %h %h %h", rd(0), rd(1), rd(2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
